// File: rtl/serv_mtimer_pkg.sv
// ============================================================================
// Module   : serv_mtimer_pkg
// Purpose  : Shared definitions for the SERV machine timer. Holds the Wishbone
//            word offsets of the four 32-bit timer registers, the default
//            mtimecmp reset value and the byte-lane write merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serv_mtimer_pkg;

   // Word offsets seen on i_wb_adr (address bits [3:2])
   typedef enum logic [1:0] {
      MTIMER_ADR_MTIME_LO    = 2'd0,
      MTIMER_ADR_MTIME_HI    = 2'd1,
      MTIMER_ADR_MTIMECMP_LO = 2'd2,
      MTIMER_ADR_MTIMECMP_HI = 2'd3
   } mtimer_adr_e;

   // All-ones compare value keeps the interrupt quiet out of reset
   localparam logic [63:0] MTIMECMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

   // Replace only the byte lanes whose select bit is set
   function automatic logic [31:0] wb_byte_merge(
      input logic [31:0] old_word,
      input logic [31:0] wr_data,
      input logic [3:0]  wr_sel
   );
      logic [31:0] merged;
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = wr_sel[b] ? wr_data[8*b +: 8] : old_word[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serv_mtimer_presc.sv
// ============================================================================
// Module   : serv_mtimer_presc
// Purpose  : mtime prescaler. Counts 0..PRESCALE-1 and pulses o_tick in the
//            cycle the count equals PRESCALE-1, then wraps to 0. With
//            PRESCALE=1 no counter exists and o_tick is tied high.
// Ports    : i_clk  - clock, rising edge
//            i_rst  - asynchronous active-high reset (count -> 0)
//            o_tick - mtime increment enable
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serv_mtimer_presc #(
   parameter int PRESCALE = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   generate
      if (PRESCALE <= 1) begin : g_tick_tied
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, i_clk, i_rst};
         assign o_tick         = 1'b1;
      end else begin : g_tick_count
         localparam int            CW       = $clog2(PRESCALE);
         localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          tick;

         always_comb begin
            tick  = (cnt_q == CNT_LAST);
            cnt_d = tick ? '0 : cnt_q + CW'(1);
         end

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign o_tick = tick;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/serv_mtimer.sv
// ============================================================================
// Module   : serv_mtimer
// Purpose  : RISC-V machine timer (mtime / mtimecmp) for the SERV core as a
//            Wishbone slave. o_mtip is a registered unsigned compare
//            mtime >= mtimecmp, so it is glitch-free for serv_csr.i_mtip.
// Ports    : i_clk    - clock, rising edge
//            i_rst    - asynchronous active-high reset
//            i_wb_cyc - bus request (also acts as strobe)
//            i_wb_we  - 1 = write, 0 = read
//            i_wb_adr - word offset: 0 mtime_lo 1 mtime_hi 2 cmp_lo 3 cmp_hi
//            i_wb_dat - write data
//            i_wb_sel - write byte enables
//            o_wb_rdt - read data, valid while o_wb_ack = 1
//            o_wb_ack - single-cycle acknowledge
//            o_mtip   - timer interrupt pending
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serv_mtimer
   import serv_mtimer_pkg::*;
#(
   parameter int          PRESCALE     = 1,
   parameter logic [63:0] MTIMECMP_RST = MTIMECMP_RST_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_we,
   input  logic [1:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_mtip
);

   logic        tick;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        ack_q, ack_d;
   logic [31:0] rdt_q, rdt_d;
   logic        mtip_q, mtip_d;
   logic        wr_en;
   logic [31:0] reg_rd;
   logic [31:0] wr_word;
   mtimer_adr_e adr;

   serv_mtimer_presc #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (tick)
   );

   always_comb begin
      adr = mtimer_adr_e'(i_wb_adr);

      // Ack toggles while cyc is held, so a held cyc during ack is the
      // tail of the same transfer rather than a new request.
      ack_d = i_wb_cyc & ~ack_q;
      wr_en = ack_d & i_wb_we;

      unique case (adr)
         MTIMER_ADR_MTIME_LO:    reg_rd = mtime_q[31:0];
         MTIMER_ADR_MTIME_HI:    reg_rd = mtime_q[63:32];
         MTIMER_ADR_MTIMECMP_LO: reg_rd = mtimecmp_q[31:0];
         MTIMER_ADR_MTIMECMP_HI: reg_rd = mtimecmp_q[63:32];
      endcase

      wr_word = wb_byte_merge(reg_rd, i_wb_dat, i_wb_sel);

      // Read data is the pre-edge value of the addressed register
      rdt_d = ack_d ? reg_rd : rdt_q;

      // A write to either mtime half replaces the whole next value, so the
      // tick (and any lo->hi carry) of that cycle is dropped.
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      if (wr_en) begin
         case (adr)
            MTIMER_ADR_MTIME_LO:    mtime_d    = {mtime_q[63:32], wr_word};
            MTIMER_ADR_MTIME_HI:    mtime_d    = {wr_word, mtime_q[31:0]};
            MTIMER_ADR_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wr_word};
            MTIMER_ADR_MTIMECMP_HI: mtimecmp_d = {wr_word, mtimecmp_q[31:0]};
         endcase
      end

      mtip_d = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= MTIMECMP_RST;
         ack_q      <= 1'b0;
         rdt_q      <= '0;
         mtip_q     <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ack_q      <= ack_d;
         rdt_q      <= rdt_d;
         mtip_q     <= mtip_d;
      end
   end

   assign o_wb_rdt = rdt_q;
   assign o_wb_ack = ack_q;
   assign o_mtip   = mtip_q;

endmodule

`default_nettype wire

// File: tb/tb_serv_mtimer.sv
// ============================================================================
// Module   : tb_serv_mtimer
// Purpose  : Self-checking bench for serv_mtimer. Two instances (PRESCALE=1
//            and PRESCALE=4) share one bus; a cycle model tracks both and
//            feeds a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serv_mtimer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [1:0]  adr = 2'd0;
   logic [31:0] dat = '0;
   logic [3:0]  sel = '0;
   logic [31:0] rdt0, rdt1;
   logic        ack0, ack1, mtip0, mtip1;

   always #5 clk = ~clk;

   serv_mtimer #(.PRESCALE(1)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr),
      .i_wb_dat(dat), .i_wb_sel(sel), .o_wb_rdt(rdt0), .o_wb_ack(ack0), .o_mtip(mtip0)
   );

   serv_mtimer #(.PRESCALE(4), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr),
      .i_wb_dat(dat), .i_wb_sel(sel), .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_mtip(mtip1)
   );

   int n_vec = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   logic [63:0] m_time [2];
   logic [63:0] m_cmp  [2];
   int          m_cnt  [2];
   logic        m_ack  [2];
   logic        m_mtip [2];

   function automatic int psc(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [31:0] mask_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_time[i] <= 64'd0;
            m_cmp[i]  <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_cnt[i]  <= 0;
            m_ack[i]  <= 1'b0;
            m_mtip[i] <= 1'b0;
         end else begin
            m_ack[i]  <= cyc && !m_ack[i];
            m_mtip[i] <= (m_time[i] >= m_cmp[i]);
            m_cnt[i]  <= (m_cnt[i] == psc(i) - 1) ? 0 : m_cnt[i] + 1;
            if (cyc && !m_ack[i] && we && adr == 2'd0)
               m_time[i] <= {m_time[i][63:32], mask_merge(m_time[i][31:0], dat, sel)};
            else if (cyc && !m_ack[i] && we && adr == 2'd1)
               m_time[i] <= {mask_merge(m_time[i][63:32], dat, sel), m_time[i][31:0]};
            else if (m_cnt[i] == psc(i) - 1)
               m_time[i] <= m_time[i] + 64'd1;
            if (cyc && !m_ack[i] && we && adr == 2'd2)
               m_cmp[i] <= {m_cmp[i][63:32], mask_merge(m_cmp[i][31:0], dat, sel)};
            else if (cyc && !m_ack[i] && we && adr == 2'd3)
               m_cmp[i] <= {mask_merge(m_cmp[i][63:32], dat, sel), m_cmp[i][31:0]};
         end
      end
   end

   function automatic logic [31:0] model_rd(input int i, input logic [1:0] a);
      case (a)
         2'd0:    return m_time[i][31:0];
         2'd1:    return m_time[i][63:32];
         2'd2:    return m_cmp[i][31:0];
         default: return m_cmp[i][63:32];
      endcase
   endfunction

   // ---------------- scoreboard + bus driver ----------------
   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];
   logic        obs_ack0, obs_ack1, obs_mtip0, obs_mtip1;
   logic [31:0] obs_rdt0, obs_rdt1;

   // One transfer: drive at a falling edge, ack rises on the next rising
   // edge, then cyc drops and one more edge lets ack fall.
   task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      @(negedge clk);
      cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
      if (!w) begin
         exp_q0.push_back(model_rd(0, a));
         exp_q1.push_back(model_rd(1, a));
      end
      @(posedge clk);
      #1;
      obs_ack0 = ack0; obs_ack1 = ack1;
      obs_rdt0 = rdt0; obs_rdt1 = rdt1;
      obs_mtip0 = mtip0; obs_mtip1 = mtip1;
      cyc = 1'b0; we = 1'b0;
      @(posedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] a0;
      #2 rst = 1'b1;
      #1;
      n_vec += 3;
      if (ack0 !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b expected 0", ack0); end
      if (mtip0 !== 1'b0) begin n_bad++; $display("FAIL rst_mtip: got %b expected 0", mtip0); end
      if (rdt0 !== 32'd0) begin n_bad++; $display("FAIL rst_rdt: got %h expected 0", rdt0); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // Force an interrupt so the mid-transfer reset has something to clear
      xfer(1'b1, 2'd3, 32'd0, 4'hF);
      xfer(1'b1, 2'd2, 32'd0, 4'hF);
      @(negedge clk);
      #1;
      n_vec += 2;
      if (mtip0 !== 1'b1) begin n_bad++; $display("FAIL cmp0_mtip0: got %b expected 1", mtip0); end
      if (mtip1 !== 1'b1) begin n_bad++; $display("FAIL cmp0_mtip1: got %b expected 1", mtip1); end
      @(negedge clk);
      cyc = 1'b1; we = 1'b0; adr = 2'd0;
      @(posedge clk);
      #1;
      n_vec++;
      if (ack0 !== 1'b1) begin n_bad++; $display("FAIL pre_rst_ack: got %b expected 1", ack0); end
      #2 rst = 1'b1;
      #1;
      n_vec += 5;
      if (ack0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ack0: got %b expected 0", ack0); end
      if (ack1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ack1: got %b expected 0", ack1); end
      if (mtip0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_mtip0: got %b expected 0", mtip0); end
      if (mtip1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_mtip1: got %b expected 0", mtip1); end
      if (rdt0 !== 32'd0) begin n_bad++; $display("FAIL mid_rst_rdt: got %h expected 0", rdt0); end
      cyc = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      xfer(1'b0, 2'd3, 32'd0, 4'h0);
      n_vec += 2;
      if (obs_rdt0 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp_hi0: got %h expected ffffffff", obs_rdt0); end
      if (obs_rdt1 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp_hi1: got %h expected ffffffff", obs_rdt1); end
      xfer(1'b0, 2'd0, 32'd0, 4'h0);
      a0 = obs_rdt0;
      repeat (8) @(posedge clk);
      xfer(1'b0, 2'd0, 32'd0, 4'h0);
      n_vec++;
      if ((obs_rdt0 - a0) !== 32'd10) begin n_bad++; $display("FAIL mtime_delta: got %0d expected 10", obs_rdt0 - a0); end
      exp_q0.delete(); exp_q1.delete();
   endtask

   task automatic test_compare();
      int at100 = -1;
      int rise  = -1;
      xfer(1'b1, 2'd3, 32'd0, 4'hF);
      xfer(1'b1, 2'd2, 32'd100, 4'hF);
      xfer(1'b1, 2'd0, 32'd80, 4'hF);
      for (int k = 0; k < 200 && rise < 0; k++) begin
         @(negedge clk);
         n_vec++;
         if (mtip1 !== m_mtip[1]) begin n_bad++; $display("FAIL cmp_track: got %b expected %b", mtip1, m_mtip[1]); end
         if (mtip1 === 1'b1) rise = k;
         if (m_time[1] == 64'd100 && at100 < 0) at100 = k;
      end
      n_vec++;
      if (rise < 0) begin
         n_bad++; $display("FAIL cmp_rise: got no rise in 200 cycles expected rise");
      end else if (rise != at100 + 1) begin
         n_bad++; $display("FAIL cmp_rise: got cycle %0d expected cycle %0d", rise, at100 + 1);
      end
      xfer(1'b1, 2'd2, 32'd1000, 4'hF);
      #1;
      n_vec += 2;
      if (obs_mtip1 !== 1'b1) begin n_bad++; $display("FAIL cmp_at_ack: got %b expected 1", obs_mtip1); end
      if (mtip1 !== 1'b0) begin n_bad++; $display("FAIL cmp_clear: got %b expected 0", mtip1); end
      exp_q0.delete(); exp_q1.delete();
   endtask

   task automatic test_wrap();
      logic [31:0] e1;
      xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF);
      xfer(1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF);
      xfer(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF);
      xfer(1'b1, 2'd0, 32'hFFFF_FFFE, 4'hF);
      @(negedge clk);
      n_vec++;
      if (mtip0 !== 1'b0) begin n_bad++; $display("FAIL wrap_fffe: got %b expected 0", mtip0); end
      @(negedge clk);
      n_vec++;
      if (mtip0 !== 1'b1) begin n_bad++; $display("FAIL wrap_ffff: got %b expected 1", mtip0); end
      @(negedge clk);
      n_vec++;
      if (mtip0 !== 1'b0) begin n_bad++; $display("FAIL wrap_zero: got %b expected 0", mtip0); end
      exp_q0.delete(); exp_q1.delete();
      xfer(1'b0, 2'd1, 32'd0, 4'h0);
      e1 = exp_q1.pop_front(); void'(exp_q0.pop_front());
      n_vec += 2;
      if (obs_rdt0 !== 32'd0) begin n_bad++; $display("FAIL wrap_carry_hi: got %h expected 0", obs_rdt0); end
      if (obs_rdt1 !== e1) begin n_bad++; $display("FAIL wrap_hi_dut1: got %h expected %h", obs_rdt1, e1); end
      xfer(1'b0, 2'd0, 32'd0, 4'h0);
      e1 = exp_q1.pop_front(); void'(exp_q0.pop_front());
      n_vec += 2;
      if (obs_rdt0 !== 32'd4) begin n_bad++; $display("FAIL wrap_lo: got %h expected 4", obs_rdt0); end
      if (obs_rdt1 !== e1) begin n_bad++; $display("FAIL wrap_lo_dut1: got %h expected %h", obs_rdt1, e1); end
   endtask

   task automatic test_byte_enables();
      xfer(1'b1, 2'd2, 32'h1122_3344, 4'hF);
      xfer(1'b1, 2'd2, 32'hAABB_CCDD, 4'b0101);
      xfer(1'b0, 2'd2, 32'd0, 4'h0);
      n_vec += 2;
      if (obs_rdt0 !== 32'h11BB_33DD) begin n_bad++; $display("FAIL be_0101_0: got %h expected 11bb33dd", obs_rdt0); end
      if (obs_rdt1 !== 32'h11BB_33DD) begin n_bad++; $display("FAIL be_0101_1: got %h expected 11bb33dd", obs_rdt1); end
      xfer(1'b1, 2'd2, 32'hAABB_CCDD, 4'b1010);
      xfer(1'b1, 2'd2, 32'h0000_0000, 4'b0000);
      xfer(1'b0, 2'd2, 32'd0, 4'h0);
      n_vec++;
      if (obs_rdt0 !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL be_1010: got %h expected aabbccdd", obs_rdt0); end
      exp_q0.delete(); exp_q1.delete();
   endtask

   task automatic test_collision();
      xfer(1'b1, 2'd0, 32'd5, 4'hF);
      xfer(1'b0, 2'd0, 32'd0, 4'h0);
      n_vec++;
      if (obs_rdt0 !== 32'd6) begin n_bad++; $display("FAIL coll_n1: got %0d expected 6", obs_rdt0); end
      xfer(1'b1, 2'd0, 32'd5, 4'hF);
      repeat (7) @(posedge clk);
      xfer(1'b0, 2'd0, 32'd0, 4'h0);
      n_vec++;
      if (obs_rdt0 !== 32'd13) begin n_bad++; $display("FAIL coll_n8: got %0d expected 13", obs_rdt0); end
      // Writing the high half also suppresses that cycle's increment of the low half
      xfer(1'b1, 2'd0, 32'd5, 4'hF);
      xfer(1'b1, 2'd1, 32'd3, 4'hF);
      xfer(1'b0, 2'd0, 32'd0, 4'h0);
      n_vec++;
      if (obs_rdt0 !== 32'd7) begin n_bad++; $display("FAIL coll_hi_lo: got %0d expected 7", obs_rdt0); end
      xfer(1'b0, 2'd1, 32'd0, 4'h0);
      n_vec++;
      if (obs_rdt0 !== 32'd3) begin n_bad++; $display("FAIL coll_hi: got %0d expected 3", obs_rdt0); end
      exp_q0.delete(); exp_q1.delete();
   endtask

   task automatic test_handshake();
      logic        exp_ack;
      logic [31:0] e0, e1;
      @(negedge clk);
      cyc = 1'b1; we = 1'b0; adr = 2'd0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         exp_ack = (k % 2 == 1);
         n_vec += 2;
         if (ack0 !== exp_ack) begin n_bad++; $display("FAIL hs_ack0[%0d]: got %b expected %b", k, ack0, exp_ack); end
         if (ack1 !== exp_ack) begin n_bad++; $display("FAIL hs_ack1[%0d]: got %b expected %b", k, ack1, exp_ack); end
         if (exp_ack) begin
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_vec += 2;
            if (rdt0 !== e0) begin n_bad++; $display("FAIL hs_rdt0[%0d]: got %h expected %h", k, rdt0, e0); end
            if (rdt1 !== e1) begin n_bad++; $display("FAIL hs_rdt1[%0d]: got %h expected %h", k, rdt1, e1); end
         end else begin
            exp_q0.push_back(model_rd(0, 2'd0));
            exp_q1.push_back(model_rd(1, 2'd0));
         end
      end
      cyc = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_vec++;
         if (ack0 !== 1'b0) begin n_bad++; $display("FAIL hs_idle[%0d]: got %b expected 0", k, ack0); end
      end
      exp_q0.delete(); exp_q1.delete();
   endtask

   task automatic test_back_to_back();
      logic        w;
      logic [1:0]  a;
      logic [31:0] e0, e1;
      for (int k = 0; k < 24; k++) begin
         w = 1'($urandom_range(0, 1));
         a = 2'($urandom_range(0, 3));
         xfer(w, a, $urandom, 4'($urandom_range(0, 15)));
         n_vec += 2;
         if (obs_ack0 !== 1'b1) begin n_bad++; $display("FAIL b2b_ack0[%0d]: got %b expected 1", k, obs_ack0); end
         if (obs_ack1 !== 1'b1) begin n_bad++; $display("FAIL b2b_ack1[%0d]: got %b expected 1", k, obs_ack1); end
         if (!w) begin
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_vec += 2;
            if (obs_rdt0 !== e0) begin n_bad++; $display("FAIL b2b_rdt0[%0d]: got %h expected %h", k, obs_rdt0, e0); end
            if (obs_rdt1 !== e1) begin n_bad++; $display("FAIL b2b_rdt1[%0d]: got %h expected %h", k, obs_rdt1, e1); end
         end
         #1;
         n_vec += 2;
         if (mtip0 !== m_mtip[0]) begin n_bad++; $display("FAIL b2b_mtip0[%0d]: got %b expected %b", k, mtip0, m_mtip[0]); end
         if (mtip1 !== m_mtip[1]) begin n_bad++; $display("FAIL b2b_mtip1[%0d]: got %b expected %b", k, mtip1, m_mtip[1]); end
      end
   endtask

   initial begin
      test_reset();
      test_compare();
      test_wrap();
      test_byte_enables();
      test_collision();
      test_handshake();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule

`default_nettype wire
